// File: rtl/tcs3200_pkg.sv
// Shared filter codes, FSM states and colour-class codes for the TCS3200 scan controller.
package tcs3200_pkg;

  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;
  localparam logic [1:0] FILT_GREEN = 2'b11;

  localparam logic [1:0] CID_NONE  = 2'b00;
  localparam logic [1:0] CID_RED   = 2'b01;
  localparam logic [1:0] CID_GREEN = 2'b10;
  localparam logic [1:0] CID_BLUE  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_GATE   = 3'd2,
    ST_STORE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Scan order is red, green, blue, clear; clear wraps back to red.
  function automatic logic [1:0] next_filt(input logic [1:0] f);
    case (f)
      FILT_RED:   next_filt = FILT_GREEN;
      FILT_GREEN: next_filt = FILT_BLUE;
      FILT_BLUE:  next_filt = FILT_CLEAR;
      default:    next_filt = FILT_RED;
    endcase
  endfunction

endpackage

// File: rtl/tcs3200_scan_ctrl_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge pulse; a rise on d
// shows up on rise three clk cycles later.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;

  // Synchronizer chain and edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign rise = r_rise;

endmodule

// File: rtl/tcs3200_scan_ctrl.sv
// TCS3200 scan sequencer: steps S2/S3 through red, green, blue, clear, counts
// sensor edges per gate window and publishes all four counts together.
// Optional macro COLOR_CLASS_EN adds the color_id classification output.
module tcs3200_scan_ctrl
  import tcs3200_pkg::*;
#(
  parameter int GATE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 100,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             freq_in,
  output logic             s2,
  output logic             s3,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt
`ifdef COLOR_CLASS_EN
  ,
  output logic [1:0]       color_id
`endif
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t             r_state;
  logic [1:0]         r_filt;
  logic [TMR_W-1:0]   r_tmr;
  logic [CNT_W-1:0]   r_edge;
  logic [CNT_W-1:0]   r_sh_red;
  logic [CNT_W-1:0]   r_sh_green;
  logic [CNT_W-1:0]   r_sh_blue;
  logic [CNT_W-1:0]   r_sh_clear;
  logic [CNT_W-1:0]   r_red;
  logic [CNT_W-1:0]   r_green;
  logic [CNT_W-1:0]   r_blue;
  logic [CNT_W-1:0]   r_clear;
  logic               r_busy;
  logic               r_done;
  logic               w_rise;

`ifdef COLOR_CLASS_EN
  localparam logic [CNT_W-1:0] CLR_MIN = CNT_W'(2 ** (CNT_W - 4));
  logic [1:0] r_cid;

  // Dim scenes report none; otherwise the strongest channel wins, ties red > green > blue.
  function automatic logic [1:0] classify(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] g,
                                          input logic [CNT_W-1:0] b, input logic [CNT_W-1:0] c);
    if (c < CLR_MIN)          classify = CID_NONE;
    else if (r >= g && r >= b) classify = CID_RED;
    else if (g >= b)          classify = CID_GREEN;
    else                      classify = CID_BLUE;
  endfunction

  assign color_id = r_cid;
`endif

  edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (freq_in),
    .rise  (w_rise)
  );

  // Scan sequencer with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_filt     <= FILT_RED;
      r_tmr      <= TMR_W'(0);
      r_edge     <= CNT_W'(0);
      r_sh_red   <= CNT_W'(0);
      r_sh_green <= CNT_W'(0);
      r_sh_blue  <= CNT_W'(0);
      r_sh_clear <= CNT_W'(0);
      r_red      <= CNT_W'(0);
      r_green    <= CNT_W'(0);
      r_blue     <= CNT_W'(0);
      r_clear    <= CNT_W'(0);
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef COLOR_CLASS_EN
      r_cid      <= CID_NONE;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SETTLE;
            r_busy  <= 1'b1;
            r_filt  <= FILT_RED;
            r_tmr   <= TMR_W'(0);
          end
        end
        ST_SETTLE: begin
          if (r_tmr == SETTLE_LAST) begin
            r_state <= ST_GATE;
            r_tmr   <= TMR_W'(0);
            r_edge  <= CNT_W'(0);
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        ST_GATE: begin
          if (w_rise && (r_edge != CNT_MAX)) begin
            r_edge <= r_edge + CNT_W'(1);
          end
          if (r_tmr == GATE_LAST) begin
            r_state <= ST_STORE;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        ST_STORE: begin
          case (r_filt)
            FILT_RED:   r_sh_red   <= r_edge;
            FILT_GREEN: r_sh_green <= r_edge;
            FILT_BLUE:  r_sh_blue  <= r_edge;
            default:    r_sh_clear <= r_edge;
          endcase
          if (r_filt == FILT_CLEAR) begin
            r_state <= ST_DONE;
          end else begin
            r_filt  <= next_filt(r_filt);
            r_tmr   <= TMR_W'(0);
            r_state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          r_red   <= r_sh_red;
          r_green <= r_sh_green;
          r_blue  <= r_sh_blue;
          r_clear <= r_sh_clear;
`ifdef COLOR_CLASS_EN
          r_cid   <= classify(r_sh_red, r_sh_green, r_sh_blue, r_sh_clear);
`endif
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_filt  <= FILT_RED;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_filt  <= FILT_RED;
        end
      endcase
    end
  end

  assign s2        = r_filt[1];
  assign s3        = r_filt[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign red_cnt   = r_red;
  assign green_cnt = r_green;
  assign blue_cnt  = r_blue;
  assign clear_cnt = r_clear;

endmodule

// File: doc/tcs3200_scan_ctrl.md
Name: tcs3200_scan_ctrl

Overview:
Sequencer for the TCS3200-style color sensor in the sensorcolor project. It drives the S2/S3 photodiode filter select and counts rising edges of the sensor's frequency output over a fixed gate window for each filter. The filter order is red, green, blue, clear. It publishes the four counts atomically and sits between top and the sensor pins.

Parameters:
GATE_CYCLES, 50000, clk cycles per measurement window for each filter (>=2)
SETTLE_CYCLES, 100, clk cycles after an S2/S3 change before counting starts (>=1)
CNT_W, 16, width of each channel count

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request to begin a scan; ignored while busy
freq_in  in  1  sensor frequency output, asynchronous to clk
s2  out  1  filter select bit S2
s3  out  1  filter select bit S3
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when results update
red_cnt  out  CNT_W  red channel edge count
green_cnt  out  CNT_W  green channel edge count
blue_cnt  out  CNT_W  blue channel edge count
clear_cnt  out  CNT_W  clear (unfiltered) channel edge count

Behaviour:
- Reset (async assert, sync release): state IDLE, s2=s3=0, busy=0, done=0, all counts 0, shadow registers 0.
- Filter codes {s2,s3}: RED=00, BLUE=01, CLEAR=10, GREEN=11. Scan order is RED, GREEN, BLUE, CLEAR.
- freq_in passes through a 2-flop synchronizer plus a rising-edge detector. An edge produces a one-cycle pulse 3 cycles after the freq_in rise.
- Legal input: freq_in high and low times are each >=2 clk periods. Faster input is undefined.
- FSM states:
  - IDLE: start=1 -> SETTLE. Next cycle: busy=1, {s2,s3}=RED, settle counter=0.
  - SETTLE: runs SETTLE_CYCLES cycles, then -> GATE. Edges seen in SETTLE are discarded. The edge counter clears on GATE entry.
  - GATE: runs exactly GATE_CYCLES cycles and increments the edge counter on each edge pulse. The counter saturates at 2^CNT_W-1 and never wraps. After the last GATE cycle -> STORE.
  - STORE (1 cycle): the edge count is written to the current channel's shadow register.
    - If the channel is not CLEAR: {s2,s3} advances to the next filter -> SETTLE.
    - If the channel is CLEAR -> DONE.
  - DONE (1 cycle): all four output count registers load from the shadow registers together. done=1, busy=0 -> IDLE. {s2,s3} returns to RED (00).
- Outputs hold their last values between scans. A partial scan never changes them.
- start while busy: ignored, not queued. start in the DONE cycle: ignored. start in the first IDLE cycle after DONE: accepted.
- Scan latency from start to done is 1 + 4*(SETTLE_CYCLES + GATE_CYCLES + 1) + 1 cycles.
- An edge pulse in the last GATE cycle is counted. An edge pulse in the STORE cycle is dropped.
- Reset mid-scan: immediate return to the reset values. Output counts are cleared and no done pulse is issued.

Optional Feature:
COLOR_CLASS_EN
- Defined: adds an output color_id (2 bits), registered in the DONE cycle alongside the counts.
  - 00 = none when clear_cnt < 2^(CNT_W-4).
  - Otherwise the largest of red/green/blue is reported: 01=red, 10=green, 11=blue.
  - Ties resolve red > green > blue.
  - Reset value 00.
- Not defined: the port and its comparator logic are absent; everything else is identical.

Decomposition:
- Package tcs3200_pkg: filter code localparams (FILT_RED, FILT_GREEN, FILT_BLUE, FILT_CLEAR), FSM state encodings, color_id codes.
- Sub-module edge_sync: 2-flop synchronizer plus rising-edge pulse (ports clk, rst_n, d, rise). It is reused by top for the echo input.

Test Plan:
All scenarios use GATE_CYCLES=100, SETTLE_CYCLES=4, CNT_W=8 unless noted.
1. Reset then idle: no start for 50 cycles -> s2=s3=0, busy=0, done=0, all counts 0.
2. Constant 10-cycle period freq_in, one start pulse -> done exactly 422 cycles after start. Each count is 10 ±1. During the scan, {s2,s3} steps 00, 11, 01, 10; after done it returns to 00.
3. Different freq_in period per filter phase (red 4, green 10, blue 20, clear 5 cycles) -> red≈25, green≈10, blue≈5, clear≈20 (±1 each). With COLOR_CLASS_EN defined, color_id=01.
4. freq_in period 4 with CNT_W=4 -> counts saturate at 15 without wrapping.
5. start re-pulsed at cycles 50 and 300 of a scan -> exactly one done, with no extra scan afterwards. Another start after done -> second scan runs normally.
6. rst_n asserted during blue GATE of a second scan, after a first scan completed with nonzero counts -> outputs immediately 0, no done pulse. After release, a new scan completes normally.
